// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// It accepts exceptions, interrupts and mret from execute, holds the pipeline
// while it runs the trap-entry or trap-return CSR sequence, and then issues a
// one-cycle redirect.
// Optional feature: define TRAP_VECTOR_EN for vectored interrupt targets
// (mtvec[1:0] = 01). When it is undefined, every trap goes to the base address.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic            illegal_i,
    input  logic            mret_i,
    input  logic            ex_trap_i,
    input  logic            tcmp_trap_i,
    input  logic            soft_trap_i,
    input  logic            mstatus_mie_i,
    output logic            pex_trap_rsp_o,
    output logic            ptcmp_trap_rsp_o,
    output logic            psoft_trap_rsp_o,
    output logic            trap_accept_o,
    output logic            hold_o,
    output logic            trap_csr_we_o,
    output logic [11:0]     trap_csr_addr_o,
    output logic [XLEN-1:0] trap_csr_wdata_o,
    input  logic [XLEN-1:0] trap_csr_rdata_i,
    output logic            jump_o,
    output logic [XLEN-1:0] jump_addr_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [XLEN-1:0] IRQ_BIT    = XLEN'(1) << (XLEN - 1);
    localparam logic [XLEN-1:0] CAUSE_ILL  = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_BRK  = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_ECL  = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EXT  = IRQ_BIT | XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_SOFT = IRQ_BIT | XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_TMR  = IRQ_BIT | XLEN'(7);

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, JUMP, R_MSTATUS, R_JUMP
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] mepc_reg, mcause_reg, mtval_reg;

    logic            ev_ok, exc_any, int_ok;
    logic            win_ex, win_soft, win_tcmp;
    logic            take_trap, take_mret;
    logic [XLEN-1:0] cause_next, tval_next, jump_base;
    logic            unused_rdata_lsb;

    assign unused_rdata_lsb = trap_csr_rdata_i[0];

    // Accept decision: only in IDLE with a valid instruction; gating it with
    // rst_n keeps every output at 0 while reset is held.
    always_comb begin
        ev_ok     = (state_reg == IDLE) && rst_n && inst_valid_i;
        exc_any   = illegal_i || ebreak_i || ecall_i;
        int_ok    = ev_ok && mstatus_mie_i && !exc_any;
        win_ex    = int_ok && ex_trap_i;
        win_soft  = int_ok && soft_trap_i && !ex_trap_i;
        win_tcmp  = int_ok && tcmp_trap_i && !soft_trap_i && !ex_trap_i;
        take_trap = (ev_ok && exc_any) || win_ex || win_soft || win_tcmp;
        take_mret = ev_ok && mret_i && !take_trap;
        if (illegal_i)      cause_next = CAUSE_ILL;
        else if (ebreak_i)  cause_next = CAUSE_BRK;
        else if (ecall_i)   cause_next = CAUSE_ECL;
        else if (win_ex)    cause_next = CAUSE_EXT;
        else if (win_soft)  cause_next = CAUSE_SOFT;
        else                cause_next = CAUSE_TMR;
        if (illegal_i)      tval_next = XLEN'(inst_i);
        else if (ebreak_i)  tval_next = pc_i;
        else                tval_next = '0;
    end

    assign trap_accept_o    = take_trap || take_mret;
    assign hold_o           = trap_accept_o || (state_reg != IDLE);
    assign pex_trap_rsp_o   = win_ex;
    assign psoft_trap_rsp_o = win_soft;
    assign ptcmp_trap_rsp_o = win_tcmp;

    // Sequencer state and trap capture; reset aborts any sequence at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mepc_reg   <= '0;
            mcause_reg <= '0;
            mtval_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take_trap) begin
                        mepc_reg   <= pc_i;
                        mcause_reg <= cause_next;
                        mtval_reg  <= tval_next;
                        state_reg  <= W_MEPC;
                    end else if (take_mret) begin
                        state_reg  <= R_MSTATUS;
                    end
                end
                W_MEPC:    state_reg <= W_MCAUSE;
                W_MCAUSE:  state_reg <= W_MTVAL;
                W_MTVAL:   state_reg <= W_MSTATUS;
                W_MSTATUS: state_reg <= JUMP;
                R_MSTATUS: state_reg <= R_JUMP;
                default:   state_reg <= IDLE;
            endcase
        end
    end

    // CSR channel and redirect decode; read-modify-write uses same-cycle rdata.
    always_comb begin
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = 12'h000;
        trap_csr_wdata_o = '0;
        jump_o           = 1'b0;
        jump_addr_o      = '0;
        jump_base        = {trap_csr_rdata_i[XLEN-1:2], 2'b00};
        case (state_reg)
            W_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MEPC;
                trap_csr_wdata_o = mepc_reg;
            end
            W_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MCAUSE;
                trap_csr_wdata_o = mcause_reg;
            end
            W_MTVAL: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MTVAL;
                trap_csr_wdata_o = mtval_reg;
            end
            W_MSTATUS: begin
                trap_csr_we_o       = 1'b1;
                trap_csr_addr_o     = CSR_MSTATUS;
                trap_csr_wdata_o[7] = trap_csr_rdata_i[3];
            end
            JUMP: begin
                trap_csr_addr_o = CSR_MTVEC;
                jump_o          = 1'b1;
                jump_addr_o     = jump_base;
`ifdef TRAP_VECTOR_EN
                if (trap_csr_rdata_i[1:0] == 2'b01 && mcause_reg[XLEN-1])
                    jump_addr_o = jump_base + {mcause_reg[XLEN-3:0], 2'b00};
`endif
            end
            R_MSTATUS: begin
                trap_csr_we_o       = 1'b1;
                trap_csr_addr_o     = CSR_MSTATUS;
                trap_csr_wdata_o[3] = trap_csr_rdata_i[7];
                trap_csr_wdata_o[7] = 1'b1;
            end
            R_JUMP: begin
                trap_csr_addr_o = CSR_MEPC;
                jump_o          = 1'b1;
                jump_addr_o     = {trap_csr_rdata_i[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl with a small trap-CSR model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] pc = '0, inst = '0;
    logic        ecall = 0, ebreak = 0, illegal = 0, mret = 0;
    logic        ex_trap = 0, tcmp_trap = 0, soft_trap = 0, mie = 0;
    logic        pex_rsp, ptcmp_rsp, psoft_rsp;
    logic        trap_accept, hold, csr_we, jump;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata, jump_addr;

    int tests = 0;
    int failed = 0;

    // CSR model state, with a preload port so only one process writes it
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        ld = 1'b0;
    logic [31:0] ld_mstatus = '0, ld_mtvec = '0, ld_mepc = '0, ld_mtval = '0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid), .pc_i(pc), .inst_i(inst),
        .ecall_i(ecall), .ebreak_i(ebreak), .illegal_i(illegal), .mret_i(mret),
        .ex_trap_i(ex_trap), .tcmp_trap_i(tcmp_trap), .soft_trap_i(soft_trap),
        .mstatus_mie_i(mie), .pex_trap_rsp_o(pex_rsp), .ptcmp_trap_rsp_o(ptcmp_rsp),
        .psoft_trap_rsp_o(psoft_rsp), .trap_accept_o(trap_accept), .hold_o(hold),
        .trap_csr_we_o(csr_we), .trap_csr_addr_o(csr_addr), .trap_csr_wdata_o(csr_wdata),
        .trap_csr_rdata_i(csr_rdata), .jump_o(jump), .jump_addr_o(jump_addr)
    );

    // combinational CSR read, as the real CSR block provides
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            12'h343: csr_rdata = m_mtval;
            default: csr_rdata = '0;
        endcase
    end

    // CSR writes from the trap channel, or a bench preload
    always @(posedge clk) begin
        if (ld) begin
            m_mstatus <= ld_mstatus;
            m_mtvec   <= ld_mtvec;
            m_mepc    <= ld_mepc;
            m_mcause  <= 32'h0;
            m_mtval   <= ld_mtval;
        end else if (csr_we) begin
            case (csr_addr)
                12'h300: m_mstatus <= csr_wdata;
                12'h305: m_mtvec   <= csr_wdata;
                12'h341: m_mepc    <= csr_wdata;
                12'h342: m_mcause  <= csr_wdata;
                12'h343: m_mtval   <= csr_wdata;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, act);
        end
    endtask

    task automatic preload(input logic [31:0] ms, input logic [31:0] tv,
                           input logic [31:0] ep, input logic [31:0] tval);
        @(negedge clk);
        ld_mstatus = ms; ld_mtvec = tv; ld_mepc = ep; ld_mtval = tval; ld = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
    endtask

    // ev = {illegal, ebreak, ecall, mret, ex, tcmp, soft, mie}; checks cycle 0
    task automatic start(input string tag, input logic [31:0] p, input logic [31:0] ins,
                         input logic [7:0] ev, input logic exp_acc, input logic [2:0] exp_rsp);
        @(negedge clk);
        inst_valid = 1'b1; pc = p; inst = ins;
        {illegal, ebreak, ecall, mret, ex_trap, tcmp_trap, soft_trap, mie} = ev;
        #1;
        check({tag, ".accept"}, {31'b0, trap_accept}, {31'b0, exp_acc});
        check({tag, ".hold0"},  {31'b0, hold},        {31'b0, exp_acc});
        check({tag, ".rsp0"},   {29'b0, pex_rsp, ptcmp_rsp, psoft_rsp}, {29'b0, exp_rsp});
        @(posedge clk);
        #1;
        inst_valid = 1'b0; illegal = 0; ebreak = 0; ecall = 0; mret = 0;
    endtask

    // cycles 1..6 of a trap entry and the resulting CSR contents
    task automatic entry_expect(input string tag, input logic [31:0] e_mepc,
                                input logic [31:0] e_cause, input logic [31:0] e_tval,
                                input logic [31:0] e_ms, input logic [31:0] e_jump);
        logic [11:0] addrs [4];
        logic [31:0] datas [4];
        addrs[0] = 12'h341; addrs[1] = 12'h342; addrs[2] = 12'h343; addrs[3] = 12'h300;
        datas[0] = e_mepc;  datas[1] = e_cause; datas[2] = e_tval;  datas[3] = e_ms;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("%s.c%0d.we_hold_rsp", tag, c + 1),
                  {27'b0, csr_we, hold, pex_rsp, ptcmp_rsp, psoft_rsp}, 32'b11000);
            check($sformatf("%s.c%0d.addr", tag, c + 1), {20'b0, csr_addr}, {20'b0, addrs[c]});
            check($sformatf("%s.c%0d.wdata", tag, c + 1), csr_wdata, datas[c]);
        end
        @(negedge clk);
        check({tag, ".c5.jump_hold_we"}, {29'b0, jump, hold, csr_we}, 32'b110);
        check({tag, ".c5.target"}, jump_addr, e_jump);
        @(negedge clk);
        check({tag, ".c6.jump_hold"}, {30'b0, jump, hold}, 32'b0);
        check({tag, ".mepc"},    m_mepc,    e_mepc);
        check({tag, ".mcause"},  m_mcause,  e_cause);
        check({tag, ".mtval"},   m_mtval,   e_tval);
        check({tag, ".mstatus"}, m_mstatus, e_ms);
    endtask

    initial begin
        logic [31:0] exp_ext_jump, exp_soft_jump;
`ifdef TRAP_VECTOR_EN
        exp_ext_jump  = 32'h22C;
        exp_soft_jump = 32'h20C;
`else
        exp_ext_jump  = 32'h200;
        exp_soft_jump = 32'h200;
`endif
        // reset state
        #12;
        check("reset.outputs", {20'b0, pex_rsp, ptcmp_rsp, psoft_rsp, trap_accept, hold,
                                csr_we, jump, 1'b0, 4'b0}, 32'h0);
        check("reset.addr",   {20'b0, csr_addr}, 32'h0);
        check("reset.wdata",  csr_wdata, 32'h0);
        check("reset.jaddr",  jump_addr, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // ecall
        preload(32'h08, 32'h200, 32'h0, 32'h0);
        start("ecall", 32'h100, 32'h73, 8'b0010_0000, 1'b1, 3'b000);
        entry_expect("ecall", 32'h100, 32'd11, 32'h0, 32'h80, 32'h200);

        // external interrupt, level held through the sequence
        preload(32'h08, 32'h201, 32'h0, 32'h0);
        start("ext", 32'h400, 32'h13, 8'b0000_1001, 1'b1, 3'b100);
        entry_expect("ext", 32'h400, 32'h8000000B, 32'h0, 32'h80, exp_ext_jump);
        ex_trap = 1'b0; mie = 1'b0;

        // timer with MIE = 0: nothing happens
        preload(32'h00, 32'h200, 32'h0, 32'h0);
        start("tmr_masked", 32'h180, 32'h13, 8'b0000_0100, 1'b0, 3'b000);
        @(negedge clk);
        check("tmr_masked.c1.we_hold", {30'b0, csr_we, hold}, 32'h0);
        tcmp_trap = 1'b0;

        // illegal wins over external interrupt; exceptions use base address
        preload(32'h08, 32'h201, 32'h0, 32'h0);
        start("ill", 32'h300, 32'hFFFFFFFF, 8'b1000_1001, 1'b1, 3'b000);
        entry_expect("ill", 32'h300, 32'h2, 32'hFFFFFFFF, 32'h80, 32'h200);
        ex_trap = 1'b0; mie = 1'b0;

        // ebreak: mtval = pc
        preload(32'h00, 32'h240, 32'h0, 32'h0);
        start("ebrk", 32'h2A0, 32'h00100073, 8'b0100_0000, 1'b1, 3'b000);
        entry_expect("ebrk", 32'h2A0, 32'h3, 32'h2A0, 32'h00, 32'h240);

        // mret
        preload(32'h80, 32'h200, 32'h104, 32'h0);
        start("mret", 32'h500, 32'h30200073, 8'b0001_0000, 1'b1, 3'b000);
        @(negedge clk);
        check("mret.c1.we_hold", {30'b0, csr_we, hold}, 32'b11);
        check("mret.c1.addr", {20'b0, csr_addr}, 32'h300);
        check("mret.c1.wdata", csr_wdata, 32'h88);
        @(negedge clk);
        check("mret.c2.jump_hold_we", {29'b0, jump, hold, csr_we}, 32'b110);
        check("mret.c2.target", jump_addr, 32'h104);
        @(negedge clk);
        check("mret.c3.jump_hold", {30'b0, jump, hold}, 32'b0);
        check("mret.mstatus", m_mstatus, 32'h88);

        // software interrupt coincident with mret: interrupt wins
        preload(32'h08, 32'h201, 32'h0, 32'h0);
        start("soft_mret", 32'h700, 32'h30200073, 8'b0001_0011, 1'b1, 3'b001);
        entry_expect("soft_mret", 32'h700, 32'h80000003, 32'h0, 32'h80, exp_soft_jump);
        soft_trap = 1'b0; mie = 1'b0;

        // reset during W_MCAUSE aborts the sequence
        preload(32'h08, 32'h200, 32'h0, 32'h55);
        start("rst", 32'h600, 32'h73, 8'b0010_0000, 1'b1, 3'b000);
        @(negedge clk);
        @(negedge clk);
        check("rst.in_mcause", {20'b0, csr_addr}, 32'h342);
        rst_n = 1'b0;
        #1;
        check("rst.outputs", {26'b0, trap_accept, hold, csr_we, jump, 2'b0}, 32'h0);
        check("rst.addr", {20'b0, csr_addr}, 32'h0);
        check("rst.wdata", csr_wdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst.mtval", m_mtval, 32'h55);
        check("rst.mstatus", m_mstatus, 32'h08);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.after_hold", {31'b0, hold}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
